// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage Y86-64 core.
// Owns the fetch PC, derives stall/bubble controls for the F/D/E/M/W
// pipeline registers, tracks run/halt/error state and counts events.
// There are no valid/ready handshakes here: every input is a level sampled
// each cycle, and every output is either registered or a pure function of
// the current inputs and the registered run state.
module pipe_ctrl #(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      f_predPC,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic             M_cnd,
   input  logic [63:0]      M_valA,
   input  logic [3:0]       W_icode,
   input  logic [63:0]      W_valM,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic [63:0]      PC,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic [1:0]       run_state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] misp_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   localparam logic [3:0] I_JXX   = 4'd7;
   localparam logic [3:0] I_RET   = 4'd9;
   localparam logic [3:0] I_MRMOV = 4'd5;
   localparam logic [3:0] I_POP   = 4'd11;
   localparam logic [3:0] R_NONE  = 4'hF;
   localparam logic [2:0] S_AOK   = 3'd0;
   localparam logic [2:0] S_HLT   = 3'd1;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic load_use, ret_haz, misp, exc_m, exc_w;
   logic redir_m, redir_w, in_run;

   // Hazard detection from the current contents of the pipeline registers
   always_comb begin
      load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                 (E_dstM != R_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      misp     = (E_icode == I_JXX) && !e_cnd;
      exc_m    = (m_stat != S_AOK);
      exc_w    = (W_stat != S_AOK);
      redir_m  = (M_icode == I_JXX) && !M_cnd;
      redir_w  = (W_icode == I_RET);
      in_run   = (state_q == ST_RUN);
   end

   // Pipeline register controls; once stopped, freeze F/D/W and inject nothing
   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b1;
      if (in_run) begin
         F_stall  = load_use || ret_haz;
         D_stall  = load_use;
         D_bubble = misp || (!load_use && ret_haz);
         E_bubble = misp || load_use;
         M_bubble = exc_m || exc_w;
         W_stall  = exc_w;
      end
   end

   // Next run state: the first faulting instruction to reach writeback decides
   always_comb begin
      state_d = state_q;
      if (in_run && exc_w) begin
         state_d = (W_stat == S_HLT) ? ST_HALT : ST_ERR;
      end
   end

   // Run state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   assign run_state = state_q;

   // Fetch PC: redirects from M and W win over the fetch stall
   always_ff @(posedge clk) begin
      if (rst) begin
         PC <= RESET_PC;
      end else if (in_run) begin
         if (redir_m)       PC <= M_valA;
         else if (redir_w)  PC <= W_valM;
         else if (!F_stall) PC <= f_predPC;
      end
   end

   // Performance counters, advancing only while running
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         lu_cnt    <= '0;
         misp_cnt  <= '0;
         ret_cnt   <= '0;
      end else if (in_run) begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (load_use)             lu_cnt   <= lu_cnt + CNT_W'(1);
         if (misp)                 misp_cnt <= misp_cnt + CNT_W'(1);
         if (ret_haz && !load_use) ret_cnt  <= ret_cnt + CNT_W'(1);
      end
   end

endmodule
